// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types, default widths and helpers for the APB master
package apb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } apb_state_t;

   localparam int APB_ADDR_W = 32;
   localparam int APB_DATA_W = 32;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/apb_slave_decode.sv
// rtl/apb_slave_decode.sv - combinational one-hot slave select from the address index field
module apb_slave_decode
   import apb_pkg::*;
#(
   parameter int ADDR_W  = APB_ADDR_W,
   parameter int NSLV    = 4,
   parameter int SLV_LSB = 12
) (
   input  logic [ADDR_W-1:0] cmd_addr,
   output logic [NSLV-1:0]   sel,
   output logic              dec_err
);

   localparam int SW = (clog2(NSLV) > 1) ? clog2(NSLV) : 1;

   logic [SW-1:0] w_idx;
   logic          w_unused_addr;

   assign w_idx         = cmd_addr[SLV_LSB +: SW];
   assign w_unused_addr = ^cmd_addr;

   // An index past the last slave selects nothing and flags a decode error.
   always_comb begin
      sel = '0;
      for (int i = 0; i < NSLV; i++) begin
         if (int'(w_idx) == i) sel[i] = 1'b1;
      end
      dec_err = ~|sel;
   end

endmodule

// File: rtl/apb_master_param.sv
// rtl/apb_master_param.sv - parametrised APB4 master, cmd/rsp handshake, optional timeout (APB_MASTER_TIMEOUT_EN)
module apb_master_param
   import apb_pkg::*;
#(
   parameter int ADDR_W  = APB_ADDR_W,
   parameter int DATA_W  = APB_DATA_W,
   parameter int NSLV    = 4,
   parameter int SLV_LSB = 12,
   parameter int TIMEOUT = 255
) (
   input  logic                   pclk,
   input  logic                   prst,
   input  logic                   cmd_valid,
   output logic                   cmd_ready,
   input  logic                   cmd_write,
   input  logic [ADDR_W-1:0]      cmd_addr,
   input  logic [DATA_W-1:0]      cmd_wdata,
   input  logic [DATA_W/8-1:0]    cmd_strb,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [DATA_W-1:0]      rsp_rdata,
   output logic                   rsp_err,
   output logic [NSLV-1:0]        psel,
   output logic                   penable,
   output logic                   pwrite,
   output logic [ADDR_W-1:0]      paddr,
   output logic [DATA_W-1:0]      pwdata,
   output logic [DATA_W/8-1:0]    pstrb,
   input  logic [NSLV*DATA_W-1:0] prdata,
   input  logic [NSLV-1:0]        pready,
   input  logic [NSLV-1:0]        pslverr
);

   localparam int STRB_W = DATA_W / 8;

   apb_state_t        r_state, w_state_nxt;
   logic [NSLV-1:0]   r_psel, w_psel_nxt;
   logic              r_penable, w_penable_nxt;
   logic              r_pwrite, w_pwrite_nxt;
   logic [ADDR_W-1:0] r_paddr, w_paddr_nxt;
   logic [DATA_W-1:0] r_pwdata, w_pwdata_nxt;
   logic [STRB_W-1:0] r_pstrb, w_pstrb_nxt;
   logic              r_rsp_valid, w_rsp_valid_nxt;
   logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata_nxt;
   logic              r_rsp_err, w_rsp_err_nxt;

   logic [NSLV-1:0]   w_dec_sel;
   logic              w_dec_err;
   logic              w_accept;
   logic              w_sel_ready;
   logic              w_sel_err;
   logic [DATA_W-1:0] w_sel_rdata;
   logic              w_timeout;
   logic              w_done;

   apb_slave_decode #(
      .ADDR_W  (ADDR_W),
      .NSLV    (NSLV),
      .SLV_LSB (SLV_LSB)
   ) u_decode (
      .cmd_addr (cmd_addr),
      .sel      (w_dec_sel),
      .dec_err  (w_dec_err)
   );

   assign cmd_ready = (r_state == ST_IDLE);
   assign w_accept  = cmd_ready & cmd_valid;

   // Only the slave currently held in psel is observed; all others are masked.
   always_comb begin
      w_sel_ready = 1'b0;
      w_sel_err   = 1'b0;
      w_sel_rdata = '0;
      for (int i = 0; i < NSLV; i++) begin
         if (r_psel[i]) begin
            w_sel_ready = w_sel_ready | pready[i];
            w_sel_err   = w_sel_err | pslverr[i];
            w_sel_rdata = w_sel_rdata | prdata[i*DATA_W +: DATA_W];
         end
      end
   end

`ifdef APB_MASTER_TIMEOUT_EN
   localparam int TW = clog2(TIMEOUT + 1);

   logic [TW-1:0] r_tmo_cnt;

   always_ff @(posedge pclk or posedge prst) begin
      if (prst) begin
         r_tmo_cnt <= '0;
      end else if (w_accept) begin
         r_tmo_cnt <= '0;
      end else if ((r_state == ST_ACCESS) && !w_sel_ready) begin
         r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
   end

   // Fires on the stalled cycle that brings the count to TIMEOUT; a late pready still wins.
   assign w_timeout = (r_state == ST_ACCESS) && !w_sel_ready && (r_tmo_cnt == TW'(TIMEOUT - 1));
`else
   localparam int unused_timeout = TIMEOUT;

   assign w_timeout = 1'b0;
`endif

   assign w_done = (r_state == ST_ACCESS) && (w_sel_ready || w_timeout);

   always_ff @(posedge pclk or posedge prst) begin
      if (prst) r_state <= ST_IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (w_accept) w_state_nxt = w_dec_err ? ST_RESP : ST_SETUP;
         ST_SETUP:  w_state_nxt = ST_ACCESS;
         ST_ACCESS: if (w_done) w_state_nxt = ST_RESP;
         ST_RESP:   if (rsp_ready) w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_psel_nxt      = r_psel;
      w_penable_nxt   = 1'b0;
      w_pwrite_nxt    = r_pwrite;
      w_paddr_nxt     = r_paddr;
      w_pwdata_nxt    = r_pwdata;
      w_pstrb_nxt     = r_pstrb;
      w_rsp_valid_nxt = (w_state_nxt == ST_RESP);
      w_rsp_rdata_nxt = r_rsp_rdata;
      w_rsp_err_nxt   = r_rsp_err;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_paddr_nxt     = cmd_addr;
               w_pwrite_nxt    = cmd_write;
               w_pwdata_nxt    = cmd_wdata;
               w_pstrb_nxt     = cmd_write ? cmd_strb : '0;
               w_psel_nxt      = w_dec_sel;
               w_rsp_rdata_nxt = '0;
               w_rsp_err_nxt   = w_dec_err;
            end
         end
         ST_SETUP: w_penable_nxt = 1'b1;
         ST_ACCESS: begin
            if (w_done) begin
               w_psel_nxt      = '0;
               w_rsp_err_nxt   = w_sel_ready ? w_sel_err : 1'b1;
               w_rsp_rdata_nxt = (w_sel_ready && !r_pwrite && !w_sel_err) ? w_sel_rdata : '0;
            end else begin
               w_penable_nxt = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge pclk or posedge prst) begin
      if (prst) begin
         r_psel      <= '0;
         r_penable   <= 1'b0;
         r_pwrite    <= 1'b0;
         r_paddr     <= '0;
         r_pwdata    <= '0;
         r_pstrb     <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_psel      <= w_psel_nxt;
         r_penable   <= w_penable_nxt;
         r_pwrite    <= w_pwrite_nxt;
         r_paddr     <= w_paddr_nxt;
         r_pwdata    <= w_pwdata_nxt;
         r_pstrb     <= w_pstrb_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
         r_rsp_rdata <= w_rsp_rdata_nxt;
         r_rsp_err   <= w_rsp_err_nxt;
      end
   end

   assign psel      = r_psel;
   assign penable   = r_penable;
   assign pwrite    = r_pwrite;
   assign paddr     = r_paddr;
   assign pwdata    = r_pwdata;
   assign pstrb     = r_pstrb;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_master_param.sv
// tb/tb_apb_master_param.sv - randomized self-checking bench for apb_master_param
module tb_apb_master_param;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int NS = 4;
   localparam int BW = DW / 8;
   localparam int TMO = 8;

   logic          pclk = 1'b0;
   logic          prst;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic [BW-1:0] cmd_strb;
   logic          rsp_valid, rsp_ready, rsp_err;
   logic [DW-1:0] rsp_rdata;
   logic [NS-1:0] psel;
   logic          penable, pwrite;
   logic [AW-1:0] paddr;
   logic [DW-1:0] pwdata;
   logic [BW-1:0] pstrb;
   logic [NS*DW-1:0] prdata;
   logic [NS-1:0] pready, pslverr;

   logic          cmd_valid3, cmd_ready3, rsp_valid3, rsp_ready3, rsp_err3;
   logic [DW-1:0] rsp_rdata3, pwdata3;
   logic [2:0]    psel3;
   logic          penable3, pwrite3;
   logic [AW-1:0] paddr3;
   logic [BW-1:0] pstrb3;
   logic [3*DW-1:0] prdata3;
   logic [2:0]    pready3, pslverr3;
   logic          psel3_seen;

   int n_vec = 0;
   int n_err = 0;

   always #5 pclk = ~pclk;

   apb_master_param #(.ADDR_W(AW), .DATA_W(DW), .NSLV(NS), .SLV_LSB(12), .TIMEOUT(TMO)) u_dut (
      .pclk(pclk), .prst(prst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
      .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   apb_master_param #(.ADDR_W(AW), .DATA_W(DW), .NSLV(3), .SLV_LSB(12), .TIMEOUT(TMO)) u_dut3 (
      .pclk(pclk), .prst(prst),
      .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
      .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3),
      .psel(psel3), .penable(penable3), .pwrite(pwrite3), .paddr(paddr3),
      .pwdata(pwdata3), .pstrb(pstrb3), .prdata(prdata3), .pready(pready3), .pslverr(pslverr3)
   );

   always @(negedge pclk) if (psel3 != '0) psel3_seen <= 1'b1;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Target slave gets the given response; every other slave babbles randomly.
   task automatic drive_slaves(input int tgt, input logic rdy, input logic err, input logic [DW-1:0] rd);
      for (int i = 0; i < NS; i++) begin
         if (i == tgt) begin
            pready[i]  = rdy;
            pslverr[i] = err;
            prdata[i*DW +: DW] = rd;
         end else begin
            pready[i]  = 1'($urandom_range(0, 1));
            pslverr[i] = 1'($urandom_range(0, 1));
            prdata[i*DW +: DW] = $urandom;
         end
      end
   endtask

   task automatic check_reset_outs(input string tag);
      check_eq({tag, "_psel"}, psel, 0);
      check_eq({tag, "_penable"}, penable, 0);
      check_eq({tag, "_pwrite"}, pwrite, 0);
      check_eq({tag, "_paddr"}, paddr, 0);
      check_eq({tag, "_pwdata"}, pwdata, 0);
      check_eq({tag, "_pstrb"}, pstrb, 0);
      check_eq({tag, "_rsp_valid"}, rsp_valid, 0);
      check_eq({tag, "_rsp_rdata"}, rsp_rdata, 0);
      check_eq({tag, "_rsp_err"}, rsp_err, 0);
      check_eq({tag, "_cmd_ready"}, cmd_ready, 1);
   endtask

   task automatic run_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input logic [BW-1:0] strb, input int waits, input logic serr,
                          input logic [DW-1:0] rdat, input int bp);
      int            tgt;
      logic [NS-1:0] exp_sel;
      logic [DW-1:0] exp_rd;
      logic [BW-1:0] exp_strb;
      tgt      = int'(addr[13:12]);
      exp_sel  = 4'b0001 << tgt;
      exp_rd   = (!wr && !serr) ? rdat : '0;
      exp_strb = wr ? strb : '0;
      @(negedge pclk);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_strb = strb;
      drive_slaves(tgt, 1'b0, 1'($urandom_range(0, 1)), $urandom);
      check_eq("accept_ready", cmd_ready, 1);
      @(negedge pclk);
      cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_strb = BW'($urandom);
      check_eq("setup_psel", psel, exp_sel);
      check_eq("setup_penable", penable, 0);
      check_eq("setup_rsp_valid", rsp_valid, 0);
      check_eq("setup_paddr", paddr, addr);
      check_eq("setup_pwrite", pwrite, wr);
      check_eq("setup_pwdata", pwdata, wdata);
      check_eq("setup_pstrb", pstrb, exp_strb);
      drive_slaves(tgt, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      for (int k = 0; k <= waits; k++) begin
         @(negedge pclk);
         check_eq("access_psel", psel, exp_sel);
         check_eq("access_penable", penable, 1);
         check_eq("access_rsp_valid", rsp_valid, 0);
         if (k == waits) drive_slaves(tgt, 1'b1, serr, rdat);
         else            drive_slaves(tgt, 1'b0, 1'($urandom_range(0, 1)), $urandom);
      end
      @(negedge pclk);
      drive_slaves(tgt, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      check_eq("resp_valid", rsp_valid, 1);
      check_eq("resp_psel", psel, 0);
      check_eq("resp_penable", penable, 0);
      check_eq("resp_rdata", rsp_rdata, exp_rd);
      check_eq("resp_err", rsp_err, serr);
      check_eq("resp_paddr_hold", paddr, addr);
      check_eq("resp_pstrb_hold", pstrb, exp_strb);
      for (int b = 0; b < bp; b++) begin
         cmd_valid = 1'($urandom_range(0, 1));
         cmd_addr  = $urandom;
         @(negedge pclk);
         check_eq("bp_valid", rsp_valid, 1);
         check_eq("bp_rdata", rsp_rdata, exp_rd);
         check_eq("bp_err", rsp_err, serr);
         check_eq("bp_paddr", paddr, addr);
         check_eq("bp_cmd_ready", cmd_ready, 0);
      end
      rsp_ready = 1'b1;
      @(negedge pclk);
      cmd_valid = 1'b0;
      rsp_ready = 1'b0;
      check_eq("done_valid", rsp_valid, 0);
      check_eq("done_cmd_ready", cmd_ready, 1);
   endtask

   task automatic run_stuck();
      int   cycles;
      logic got;
      @(negedge pclk);
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_1000;
      drive_slaves(1, 1'b0, 1'b0, $urandom);
      @(negedge pclk);
      cmd_valid = 1'b0;
      cycles = 1;
      got = 1'b0;
      while (cycles < 1000 && !got) begin
         @(negedge pclk);
         cycles++;
         if (rsp_valid) got = 1'b1;
         drive_slaves(1, 1'b0, 1'($urandom_range(0, 1)), $urandom);
      end
`ifdef APB_MASTER_TIMEOUT_EN
      check_eq("tmo_seen", got, 1);
      check_eq("tmo_cycle", cycles, TMO + 2);
      check_eq("tmo_err", rsp_err, 1);
      check_eq("tmo_rdata", rsp_rdata, 0);
      check_eq("tmo_psel", psel, 0);
      check_eq("tmo_penable", penable, 0);
      rsp_ready = 1'b1;
      @(negedge pclk);
      rsp_ready = 1'b0;
      check_eq("tmo_idle", cmd_ready, 1);
`else
      check_eq("stuck_no_rsp", got, 0);
      check_eq("stuck_psel", psel, 4'b0010);
      check_eq("stuck_penable", penable, 1);
      prst = 1'b1;
      #1;
      check_reset_outs("stuck_rst");
      @(negedge pclk);
      prst = 1'b0;
`endif
   endtask

   initial begin
      prst = 1'b1;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
      rsp_ready = 1'b0;
      prdata = '0; pready = '0; pslverr = '0;
      cmd_valid3 = 1'b0; rsp_ready3 = 1'b0;
      prdata3 = '0; pready3 = '1; pslverr3 = '0;
      psel3_seen = 1'b0;
      #2;
      check_reset_outs("reset");
      repeat (3) @(negedge pclk);
      prst = 1'b0;

      run_txn(1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, $urandom, 0);
      run_txn(1'b0, 32'h0000_2000, $urandom, 4'hF, 3, 1'b0, 32'h1234_5678, 0);
      run_txn(1'b1, 32'h0000_3010, 32'hCAFE_F00D, 4'h3, 1, 1'b1, $urandom, 5);

      @(negedge pclk);
      cmd_valid3 = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h0000_3000;
      check_eq("dec_ready", cmd_ready3, 1);
      @(negedge pclk);
      cmd_valid3 = 1'b0;
      check_eq("dec_valid", rsp_valid3, 1);
      check_eq("dec_err", rsp_err3, 1);
      check_eq("dec_rdata", rsp_rdata3, 0);
      check_eq("dec_penable", penable3, 0);
      repeat (2) begin
         @(negedge pclk);
         check_eq("dec_hold", rsp_valid3, 1);
      end
      rsp_ready3 = 1'b1;
      @(negedge pclk);
      rsp_ready3 = 1'b0;
      check_eq("dec_done", rsp_valid3, 0);
      check_eq("dec_no_psel", psel3_seen, 0);

      for (int t = 0; t < 24; t++) begin
         run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, BW'($urandom),
                 $urandom_range(0, 5), ($urandom_range(0, 3) == 0), $urandom, $urandom_range(0, 3));
      end

      run_stuck();

      @(negedge pclk);
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_2000;
      drive_slaves(2, 1'b0, 1'b0, 32'h1234_5678);
      @(negedge pclk);
      cmd_valid = 1'b0;
      @(negedge pclk);
      check_eq("mid_penable", penable, 1);
      #2 prst = 1'b1;
      #1;
      check_reset_outs("mid_rst");
      repeat (2) begin
         @(negedge pclk);
         check_eq("mid_rst_valid", rsp_valid, 0);
      end
      prst = 1'b0;
      drive_slaves(2, 1'b1, 1'b0, 32'h1234_5678);
      repeat (3) begin
         @(negedge pclk);
         check_eq("post_rst_valid", rsp_valid, 0);
      end
      run_txn(1'b1, 32'h0000_0040, 32'h0BAD_F00D, 4'hA, 2, 1'b0, $urandom, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
